// File: rtl/membus_ram_responder.sv
// membus_ram_responder: membus slave backed by a word-organised RAM (byte-masked write, full-word read).
// Latency: rvalid is returned LATENCY cycles after the acceptance edge; one request per LATENCY+1 cycles.
// Backpressure: ready drops from the cycle after acceptance through the response cycle.
// Optional: define MEMBUS_RAM_RANGE_CHECK_EN to add membus_err and reject out-of-range requests.
module membus_ram_responder #(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    DEPTH      = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    LATENCY    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    membus_valid,
  output logic                    membus_ready,
  input  logic [ADDR_WIDTH-1:0]   membus_addr,
  input  logic                    membus_wen,
  input  logic [DATA_WIDTH-1:0]   membus_wdata,
  input  logic [DATA_WIDTH/8-1:0] membus_wmask,
  output logic                    membus_rvalid,
`ifdef MEMBUS_RAM_RANGE_CHECK_EN
  output logic                    membus_err,
`endif
  output logic [DATA_WIDTH-1:0]   membus_rdata
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_q;
  logic                  ready_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  bad_q;

  logic [ADDR_WIDTH-1:0] addr_off;
  logic [IDX_W-1:0]      req_idx;
  logic                  req_ok;
  logic                  accept;
  logic [DATA_WIDTH-1:0] merged_word;

  // Byte offset from the window base; sub-word bits are dropped and the index wraps modulo DEPTH.
  assign addr_off = membus_addr - BASE_ADDR;
  assign req_idx  = IDX_W'(addr_off >> OFF_W);
  // ready is only high in IDLE, so this is the acceptance edge.
  assign accept   = membus_valid && ready_q;

`ifdef MEMBUS_RAM_RANGE_CHECK_EN
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(DEPTH * BYTES);
  // Requests outside [BASE_ADDR, BASE_ADDR+SPAN) are answered with an error and never touch the RAM.
  assign req_ok = (membus_addr >= BASE_ADDR) && (addr_off < SPAN);
`else
  assign req_ok = 1'b1;
`endif

  // Post-write view of the addressed word, needed when the response leaves on the acceptance edge.
  always_comb begin
    merged_word = mem[req_idx];
    for (int i = 0; i < BYTES; i++) begin
      if (membus_wmask[i]) merged_word[8*i +: 8] = membus_wdata[8*i +: 8];
    end
  end

  // RAM write commits at the acceptance edge; contents survive reset. Masters keep valid low during reset.
  always_ff @(posedge clk) begin
    if (accept && membus_wen && req_ok) begin
      for (int i = 0; i < BYTES; i++) begin
        if (membus_wmask[i]) mem[req_idx][8*i +: 8] <= membus_wdata[8*i +: 8];
      end
    end
  end

  // Request FSM: IDLE accepts, BUSY counts down the latency, RESP presents one response beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      bad_q    <= 1'b0;
`ifdef MEMBUS_RAM_RANGE_CHECK_EN
      membus_err <= 1'b0;
`endif
    end else begin
      rvalid_q <= 1'b0;
`ifdef MEMBUS_RAM_RANGE_CHECK_EN
      membus_err <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (accept) begin
            idx_q   <= req_idx;
            bad_q   <= !req_ok;
            ready_q <= 1'b0;
            if (LATENCY == 1) begin
              state_q  <= RESP;
              rvalid_q <= 1'b1;
              rdata_q  <= !req_ok ? '1 : (membus_wen ? merged_word : mem[req_idx]);
`ifdef MEMBUS_RAM_RANGE_CHECK_EN
              membus_err <= !req_ok;
`endif
            end else begin
              state_q <= BUSY;
              cnt_q   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        BUSY: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q  <= RESP;
            cnt_q    <= '0;
            rvalid_q <= 1'b1;
            // The write (if any) committed at acceptance, so the array already holds the post-write word.
            rdata_q  <= bad_q ? '1 : mem[idx_q];
`ifdef MEMBUS_RAM_RANGE_CHECK_EN
            membus_err <= bad_q;
`endif
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign membus_ready  = ready_q;
  assign membus_rvalid = rvalid_q;
  assign membus_rdata  = rdata_q;

endmodule
